kgp_seq_ctrl: RTL

- Multi-cycle instruction sequencer for the KGP-RISC core.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives datapath enables and the shared instruction/data memory handshake.
- ALU operation selection stays in the existing ALU control decoder. This block supplies only operand-source and sequencing controls, plus halt/fault status and a retired-instruction counter.

---
 rtl/kgp_seq_ctrl_pkg.sv | 50 +++++
 rtl/kgp_seq_ctrl_if.sv | 22 ++
 rtl/kgp_mem_wait_timer.sv | 27 ++
 rtl/kgp_seq_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/kgp_seq_ctrl_pkg.sv
// Shared types and constants for the KGP-RISC multi-cycle sequencer:
// state encoding, opcode classes and PC source selects.
package kgp_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT,
    ST_FAULT
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_IMM,
    CLS_BR,
    CLS_LD,
    CLS_ST,
    CLS_JMP,
    CLS_HALT,
    CLS_ILL
  } op_class_t;

  localparam logic [5:0] OP_RTYPE   = 6'b000000;
  localparam logic [2:0] OP_IMM_MSB = 3'b001;
  localparam logic [1:0] OP_BR_MSB  = 2'b01;
  localparam logic [5:0] OP_LD      = 6'b100000;
  localparam logic [5:0] OP_ST      = 6'b100001;
  localparam logic [5:0] OP_JMP     = 6'b110000;
  localparam logic [5:0] OP_HALT    = 6'b111111;

  localparam logic [1:0] PC_SRC_SEQ = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_JMP = 2'd2;

  function automatic op_class_t op_classify(input logic [5:0] op);
    if (op == OP_RTYPE)              return CLS_RTYPE;
    else if (op[5:3] == OP_IMM_MSB)  return CLS_IMM;
    else if (op[5:4] == OP_BR_MSB)   return CLS_BR;
    else if (op == OP_LD)            return CLS_LD;
    else if (op == OP_ST)            return CLS_ST;
    else if (op == OP_JMP)           return CLS_JMP;
    else if (op == OP_HALT)          return CLS_HALT;
    else                             return CLS_ILL;
  endfunction

endpackage

// File: rtl/kgp_seq_ctrl_if.sv
// Shared instruction/data memory handshake between the sequencer (master)
// and the memory (slave).
interface kgp_seq_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/kgp_mem_wait_timer.sv
// Counts memory wait cycles; expired flags the wait cycle that would make
// the count reach TIMEOUT, so a transfer in that cycle still wins.
module kgp_mem_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

  logic [15:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  assign expired = en && (count_reg == LAST_WAIT);

endmodule

// File: rtl/kgp_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer: datapath enables, memory
// handshake with wait timeout, halt/fault status and retired-instruction count.
module kgp_seq_ctrl
  import kgp_seq_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [5:0]         opcode,
  input  logic               branch_taken,
  kgp_seq_ctrl_if.master     mem,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               alu_src_imm,
  output logic               reg_write,
  output logic               wb_sel_mem,
  output logic               busy,
  output logic               halted,
  output logic               fault,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   retired
);

  state_t           state_reg, state_next;
  logic [5:0]       opcode_reg;
  logic [CNT_W-1:0] retired_reg;
  logic             illegal_reg;

  op_class_t        cls_live, cls_reg;
  logic             mem_req_c, transfer, wait_clear, wait_en, wait_expired;
  logic             retire, set_illegal;

  // The instruction register holds opcode from DECODE onward; later states
  // use the copy captured in DECODE.
  assign cls_live = op_classify(opcode);
  assign cls_reg  = op_classify(opcode_reg);

  assign mem_req_c        = (state_reg == ST_FETCH) || (state_reg == ST_MEM);
  assign transfer         = mem_req_c && mem.mem_ready;
  assign mem.mem_req      = mem_req_c;
  assign mem.mem_addr_sel = (state_reg == ST_MEM);
  assign mem.mem_we       = (state_reg == ST_MEM) && (cls_reg == CLS_ST);

  // Idle cycles between requests hold the counter at zero, which covers
  // clearing on entry to FETCH and MEM.
  assign wait_clear = !mem_req_c || transfer;
  assign wait_en    = mem_req_c && !mem.mem_ready;

  kgp_mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (wait_clear),
    .en      (wait_en),
    .expired (wait_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      opcode_reg  <= '0;
      retired_reg <= '0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_DECODE) opcode_reg <= opcode;
      if (retire) retired_reg <= retired_reg + CNT_W'(1);
      if (set_illegal) illegal_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next  = state_reg;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_SRC_SEQ;
    alu_src_imm = 1'b0;
    reg_write   = 1'b0;
    wb_sel_mem  = 1'b0;
    retire      = 1'b0;
    set_illegal = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem.mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = ST_DECODE;
        end else if (wait_expired) begin
          state_next = ST_FAULT;
        end
      end
      ST_DECODE: begin
        case (cls_live)
          CLS_RTYPE, CLS_IMM, CLS_BR, CLS_LD, CLS_ST: state_next = ST_EXEC;
          CLS_JMP: begin
            pc_write   = 1'b1;
            pc_src     = PC_SRC_JMP;
            retire     = 1'b1;
            state_next = ST_FETCH;
          end
          CLS_HALT: begin
            retire     = 1'b1;
            state_next = ST_HALT;
          end
          default: begin
            set_illegal = 1'b1;
            state_next  = ST_HALT;
          end
        endcase
      end
      ST_EXEC: begin
        alu_src_imm = (cls_reg == CLS_IMM) || (cls_reg == CLS_LD) || (cls_reg == CLS_ST);
        case (cls_reg)
          CLS_RTYPE, CLS_IMM: state_next = ST_WB;
          CLS_LD, CLS_ST:     state_next = ST_MEM;
          CLS_BR: begin
            pc_write   = branch_taken;
            pc_src     = PC_SRC_BR;
            retire     = 1'b1;
            state_next = ST_FETCH;
          end
          default: state_next = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (mem.mem_ready) begin
          if (cls_reg == CLS_ST) begin
            retire     = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end else if (wait_expired) begin
          state_next = ST_FAULT;
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        wb_sel_mem = (cls_reg == CLS_LD);
        retire     = 1'b1;
        state_next = ST_FETCH;
      end
      default: state_next = state_reg;
    endcase
  end

  assign busy       = !((state_reg == ST_IDLE) || (state_reg == ST_HALT) || (state_reg == ST_FAULT));
  assign halted     = (state_reg == ST_HALT);
  assign fault      = (state_reg == ST_FAULT);
  assign illegal_op = illegal_reg;
  assign retired    = retired_reg;

endmodule
